// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces slide switches and push
// buttons into mclk, and produces registered press/release/auto-repeat and
// switch-change event pulses for the CPU port logic.
module input_conditioner #(
  parameter int NUM_SW         = 8,
  parameter int NUM_BTN        = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int DEBOUNCE_LIMIT = 50000,
  parameter int REPEAT_DELAY   = 25000000,
  parameter int REPEAT_RATE    = 5000000
) (
  input  logic               mclk,
  input  logic               reset,
  input  logic [NUM_SW-1:0]  sw_raw,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_SW-1:0]  sw_clean,
  output logic [NUM_BTN-1:0] btn_clean,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat,
  output logic               sw_changed
);

  // Switches and buttons share one debounce array: switches in the low bits.
  localparam int unsigned NCH = NUM_SW + NUM_BTN;
  localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_LIMIT - 1);
  localparam logic [31:0] RD_LAST = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RR_LAST = 32'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, RATE} rep_state_t;

  logic [NCH-1:0]       s1, s2;
  logic [NCH-1:0]       clean_q, clean_d;
  logic [CNT_WIDTH-1:0] cnt_q [NCH];
  logic [CNT_WIDTH-1:0] cnt_d [NCH];

  logic [NUM_BTN-1:0]   btn_rise, btn_fall, rep_fire;
  logic                 sw_chg_d;
  rep_state_t           state_q [NUM_BTN];
  rep_state_t           state_d [NUM_BTN];
  logic [31:0]          rc_q [NUM_BTN];
  logic [31:0]          rc_d [NUM_BTN];

  // Debounce next state: any agreement clears the count, a full run of
  // disagreeing samples flips the clean level.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      clean_d[i] = clean_q[i];
      cnt_d[i]   = '0;
      if (s2[i] != clean_q[i]) begin
        if (cnt_q[i] == DB_LAST) clean_d[i] = s2[i];
        else                     cnt_d[i]   = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  // Edge detection compares next-state with current clean so pulses line up
  // with the clean change.
  always_comb begin
    btn_rise = clean_d[NCH-1:NUM_SW] & ~clean_q[NCH-1:NUM_SW];
    btn_fall = ~clean_d[NCH-1:NUM_SW] & clean_q[NCH-1:NUM_SW];
    sw_chg_d = |(clean_d[NUM_SW-1:0] ^ clean_q[NUM_SW-1:0]);
  end

  // Per-button repeat FSM next state; release overrides a coincident repeat.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BTN; b++) begin
      state_d[b]  = state_q[b];
      rc_d[b]     = rc_q[b];
      rep_fire[b] = 1'b0;
      case (state_q[b])
        IDLE: begin
          if (btn_rise[b]) begin
            state_d[b] = DELAY;
            rc_d[b]    = '0;
          end
        end
        DELAY: begin
          if (rc_q[b] == RD_LAST) begin
            rep_fire[b] = 1'b1;
            rc_d[b]     = '0;
            state_d[b]  = RATE;
          end else begin
            rc_d[b] = rc_q[b] + 32'd1;
          end
        end
        RATE: begin
          if (rc_q[b] == RR_LAST) begin
            rep_fire[b] = 1'b1;
            rc_d[b]     = '0;
          end else begin
            rc_d[b] = rc_q[b] + 32'd1;
          end
        end
        default: begin
          state_d[b] = IDLE;
          rc_d[b]    = '0;
        end
      endcase
      if (btn_fall[b]) begin
        state_d[b]  = IDLE;
        rc_d[b]     = '0;
        rep_fire[b] = 1'b0;
      end
    end
  end

  // Synchroniser, debounce and repeat state registers.
  always_ff @(posedge mclk) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      clean_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= '0;
      for (int unsigned b = 0; b < NUM_BTN; b++) begin
        state_q[b] <= IDLE;
        rc_q[b]    <= '0;
      end
    end else begin
      s1      <= {btn_raw, sw_raw};
      s2      <= s1;
      clean_q <= clean_d;
      for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
      for (int unsigned b = 0; b < NUM_BTN; b++) begin
        state_q[b] <= state_d[b];
        rc_q[b]    <= rc_d[b];
      end
    end
  end

  // Registered single-cycle event pulses.
  always_ff @(posedge mclk) begin
    if (reset) begin
      btn_press   <= '0;
      btn_release <= '0;
      btn_repeat  <= '0;
      sw_changed  <= 1'b0;
    end else begin
      btn_press   <= btn_rise;
      btn_release <= btn_fall;
      btn_repeat  <= rep_fire;
      sw_changed  <= sw_chg_d;
    end
  end

  assign sw_clean  = clean_q[NUM_SW-1:0];
  assign btn_clean = clean_q[NCH-1:NUM_SW];

endmodule
